// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse channel note sequencer.
package pulse_seq_pkg;

   localparam int unsigned DUR_UNIT_DEFAULT = 64;

   // note_data layout: [27:17] timer, [16:14] duty, [13:8] volume, [7:0] duration
   localparam int unsigned NOTE_W    = 28;
   localparam int unsigned TIMER_LSB = 17;
   localparam int unsigned TIMER_W   = 11;
   localparam int unsigned DUTY_LSB  = 14;
   localparam int unsigned DUTY_W    = 3;
   localparam int unsigned VOL_LSB   = 8;
   localparam int unsigned VOL_W     = 6;
   localparam int unsigned DUR_LSB   = 0;
   localparam int unsigned DUR_W     = 8;

   localparam int unsigned CNT_W      = 14;
   localparam int unsigned CFG_ADDR_W = 3;

   localparam logic [CFG_ADDR_W-1:0] CFG_REG1 = 3'd0;
   localparam logic [CFG_ADDR_W-1:0] CFG_REG2 = 3'd1;
   localparam logic [CFG_ADDR_W-1:0] CFG_REG3 = 3'd2;
   localparam logic [CFG_ADDR_W-1:0] CFG_REG4 = 3'd3;
   localparam logic [CFG_ADDR_W-1:0] CFG_REG8 = 3'd4;
   localparam logic [CFG_ADDR_W-1:0] CFG_PAN  = 3'd5;
   localparam logic [CFG_ADDR_W-1:0] CFG_ENV  = 3'd6;
   localparam logic [CFG_ADDR_W-1:0] CFG_REG7 = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_PLAY   = 3'd3,
      ST_STARVE = 3'd4
   } state_t;

   typedef struct packed {
      logic [TIMER_W-1:0] timer;
      logic [DUTY_W-1:0]  duty;
      logic [VOL_W-1:0]   volume;
      logic [DUR_W-1:0]   duration;
   } note_t;

   // Duration 0 means 256 units; 256*64 truncates to 0 in 14 bits, and the
   // wrapping down-count then expires after exactly 16384 ticks.
   function automatic logic [CNT_W-1:0] dur_count(input logic [DUR_W-1:0] dur,
                                                  input int unsigned unit);
      int unsigned eff;
      eff = (dur == '0) ? 32'd256 : 32'(dur);
      return CNT_W'(eff * unit);
   endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO with registered read data (non-fall-through) and flush.
module note_fifo #(
   parameter int unsigned WIDTH = 28,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_50mhz,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && !full && !flush;
   assign rd_en = pop && !empty;

   // Storage array, written on accepted pushes.
   always_ff @(posedge clk_50mhz) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // Pointers, occupancy and registered read port.
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (rd_en) rd_data <= mem[rd_ptr];
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)      count <= count + CW'(1);
            else if (!wr_en && rd_en) count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Note sequencer feeding a pulse channel register image from a note FIFO.
module pulse_seq_ctrl
   import pulse_seq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DUR_UNIT   = DUR_UNIT_DEFAULT
) (
   input  logic                  clk_50mhz,
   input  logic                  reset_n,
   input  logic                  tick_8khz,
   input  logic                  note_valid,
   output logic                  note_ready,
   input  logic [NOTE_W-1:0]     note_data,
   input  logic                  cfg_we,
   input  logic [CFG_ADDR_W-1:0] cfg_addr,
   input  logic [7:0]            cfg_wdata,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  flush,
   output logic                  busy,
   output logic                  note_done,
   output logic [7:0]            reg_0,
   output logic [7:0]            reg_1,
   output logic [7:0]            reg_2,
   output logic [7:0]            reg_3,
   output logic [7:0]            reg_4,
   output logic [7:0]            reg_5,
   output logic [7:0]            reg_6,
   output logic [7:0]            reg_7,
   output logic [7:0]            reg_8
);

   state_t             state_q, state_d;
   logic               pop, load, halt, silence, expire;
   logic               fifo_full, fifo_empty;
   logic [NOTE_W-1:0]  fifo_rd;
   logic [CNT_W-1:0]   cnt_q;
   logic [7:0]         stg_1, stg_2, stg_3, stg_4, stg_8;
   logic [4:0]         stg_pan, stg_r7;
   logic               stg_env;
   logic [TIMER_W-1:0] nt_timer;
   logic [DUTY_W-1:0]  nt_duty;
   logic [VOL_W-1:0]   nt_vol;
   logic [DUR_W-1:0]   nt_dur;

   note_fifo #(.WIDTH(NOTE_W), .DEPTH(FIFO_DEPTH)) u_note_fifo (
      .clk_50mhz (clk_50mhz),
      .reset_n   (reset_n),
      .push      (note_valid),
      .pop       (pop),
      .flush     (flush),
      .wr_data   (note_data),
      .rd_data   (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign note_ready = ~fifo_full;
   assign note_done  = expire;

   assign nt_timer = fifo_rd[TIMER_LSB +: TIMER_W];
   assign nt_duty  = fifo_rd[DUTY_LSB +: DUTY_W];
   assign nt_vol   = fifo_rd[VOL_LSB +: VOL_W];
   assign nt_dur   = fifo_rd[DUR_LSB +: DUR_W];

   // State register; busy follows the next state so it is a flop output.
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != ST_IDLE);
      end
   end

   // Next-state and per-cycle control strobes; stop outranks everything.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      load    = 1'b0;
      halt    = 1'b0;
      silence = 1'b0;
      expire  = 1'b0;
      if (stop && (state_q != ST_IDLE)) begin
         halt    = 1'b1;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_LOAD;
               end else begin
                  silence = 1'b1;
                  state_d = ST_STARVE;
               end
            end
            ST_STARVE: if (!fifo_empty) state_d = ST_FETCH;
            ST_LOAD: begin
               load    = 1'b1;
               state_d = ST_PLAY;
            end
            ST_PLAY: begin
               if (tick_8khz && (cnt_q == CNT_W'(1))) begin
                  expire  = 1'b1;
                  state_d = ST_FETCH;
               end
            end
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Duration down-counter, loaded per note and stepped by the 8 kHz strobe.
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= dur_count(nt_dur, DUR_UNIT);
      end else if ((state_q == ST_PLAY) && tick_8khz && !halt) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Staging registers written by the config port in any state.
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         stg_1   <= '0;
         stg_2   <= '0;
         stg_3   <= '0;
         stg_4   <= '0;
         stg_8   <= '0;
         stg_pan <= '0;
         stg_env <= 1'b0;
         stg_r7  <= '0;
      end else if (cfg_we) begin
         case (cfg_addr)
            CFG_REG1: stg_1   <= cfg_wdata;
            CFG_REG2: stg_2   <= cfg_wdata;
            CFG_REG3: stg_3   <= cfg_wdata;
            CFG_REG4: stg_4   <= cfg_wdata;
            CFG_REG8: stg_8   <= cfg_wdata;
            CFG_PAN:  stg_pan <= cfg_wdata[4:0];
            CFG_ENV:  stg_env <= cfg_wdata[7];
            CFG_REG7: stg_r7  <= cfg_wdata[7:3];
            default:  ;
         endcase
      end
   end

   // Register image: staging copy, note load, and volume silencing.
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         reg_0 <= '0;
         reg_1 <= '0;
         reg_2 <= '0;
         reg_3 <= '0;
         reg_4 <= '0;
         reg_5 <= '0;
         reg_6 <= '0;
         reg_7 <= '0;
         reg_8 <= '0;
      end else begin
         if ((state_q == ST_IDLE) || load) begin
            reg_0[7]   <= stg_env;
            reg_1      <= stg_1;
            reg_2      <= stg_2;
            reg_3      <= stg_3;
            reg_4      <= stg_4;
            reg_5[4:0] <= stg_pan;
            reg_7[7:3] <= stg_r7;
            reg_8      <= stg_8;
         end
         if (load) begin
            reg_0[5:0] <= nt_vol;
            // Retrigger bit flips for every sounding note, never for a rest.
            if (nt_vol != '0) reg_0[6] <= ~reg_0[6];
            reg_5[7:5] <= nt_duty;
            reg_6      <= nt_timer[7:0];
            reg_7[2:0] <= nt_timer[10:8];
         end
         if (halt || silence) reg_0[5:0] <= '0;
      end
   end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl with a note scoreboard and register model.
module tb_pulse_seq_ctrl;
   import pulse_seq_pkg::*;

   logic        clk_50mhz = 1'b0;
   logic        reset_n;
   logic        tick_8khz, note_valid, note_ready;
   logic [27:0] note_data;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [7:0]  cfg_wdata;
   logic        start, stop, flush, busy, note_done;
   logic [7:0]  reg_0, reg_1, reg_2, reg_3, reg_4, reg_5, reg_6, reg_7, reg_8;

   always #10 clk_50mhz = ~clk_50mhz;

   pulse_seq_ctrl #(.FIFO_DEPTH(8), .DUR_UNIT(64)) dut (
      .clk_50mhz (clk_50mhz), .reset_n (reset_n), .tick_8khz (tick_8khz),
      .note_valid(note_valid), .note_ready(note_ready), .note_data(note_data),
      .cfg_we    (cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start     (start), .stop(stop), .flush(flush),
      .busy      (busy), .note_done(note_done),
      .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3), .reg_4(reg_4),
      .reg_5(reg_5), .reg_6(reg_6), .reg_7(reg_7), .reg_8(reg_8)
   );

   int vectors = 0;
   int miscompares = 0;

   note_t      exp_q[$];
   int         mdl_cnt = 0;
   logic [7:0] m_stg [4];
   logic [7:0] m_stg8;
   logic [4:0] m_pan, m_hi;
   logic       m_env, m_tog;
   logic [5:0] m_vol;
   logic [10:0] m_timer;
   logic [2:0] m_duty;

   task automatic cyc();
      @(posedge clk_50mhz);
      #1;
   endtask

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic note_t mk(input logic [10:0] t, input logic [2:0] d,
                                input logic [5:0] v, input logic [7:0] u);
      note_t n;
      n.timer = t; n.duty = d; n.volume = v; n.duration = u;
      return n;
   endfunction

   function automatic logic [71:0] obs_regs();
      return {reg_0, reg_1, reg_2, reg_3, reg_4, reg_5, reg_6, reg_7, reg_8};
   endfunction

   function automatic logic [71:0] exp_regs();
      return {m_env, m_tog, m_vol, m_stg[0], m_stg[1], m_stg[2], m_stg[3],
              m_duty, m_pan, m_timer[7:0], m_hi, m_timer[10:8], m_stg8};
   endfunction

   task automatic check_regs(input string tag);
      check(tag, obs_regs(), exp_regs());
   endtask

   task automatic model_reset();
      foreach (m_stg[i]) m_stg[i] = 8'h00;
      m_stg8 = '0; m_pan = '0; m_hi = '0; m_env = 1'b0; m_tog = 1'b0;
      m_vol = '0; m_timer = '0; m_duty = '0;
      exp_q.delete();
      mdl_cnt = 0;
   endtask

   task automatic push_note(input string tag, input note_t n);
      check(tag, 72'(note_ready), 72'(mdl_cnt < 8));
      note_valid = 1'b1;
      note_data  = n;
      cyc();
      note_valid = 1'b0;
      if (mdl_cnt < 8) begin
         exp_q.push_back(n);
         mdl_cnt++;
      end
   endtask

   task automatic check_load(input string tag);
      note_t n;
      n = exp_q.pop_front();
      mdl_cnt--;
      if (n.volume != 6'd0) m_tog = ~m_tog;
      m_vol = n.volume; m_timer = n.timer; m_duty = n.duty;
      check_regs(tag);
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      cyc();
      cfg_we = 1'b0;
      case (a)
         3'd0: m_stg[0] = d;
         3'd1: m_stg[1] = d;
         3'd2: m_stg[2] = d;
         3'd3: m_stg[3] = d;
         3'd4: m_stg8 = d;
         3'd5: m_pan = d[4:0];
         3'd6: m_env = d[7];
         default: m_hi = d[7:3];
      endcase
   endtask

   // Ticks every other cycle until note_done; returns just after the expiry edge.
   task automatic run_note(input string tag, input int exp_ticks);
      int  n;
      bit  seen;
      n = 0; seen = 1'b0;
      while (!seen && n < exp_ticks + 8) begin
         tick_8khz = 1'b1;
         #1;
         n++;
         if (note_done === 1'b1) seen = 1'b1;
         cyc();
         tick_8khz = 1'b0;
         if (!seen) cyc();
      end
      check(tag, 72'(n), 72'(exp_ticks));
   endtask

   initial begin
      note_t a, r;
      reset_n = 1'b1; tick_8khz = 1'b0; note_valid = 1'b0; note_data = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      start = 1'b0; stop = 1'b0; flush = 1'b0;
      model_reset();
      #5 reset_n = 1'b0;
      cyc(); cyc(); cyc();
      check_regs("reset_regs");
      check("reset_busy", 72'(busy), 72'(0));
      check("reset_ready", 72'(note_ready), 72'(1));
      check("reset_done", 72'(note_done), 72'(0));
      reset_n = 1'b1;
      cyc();

      // Staging writes in IDLE are mirrored the following cycle.
      cfg_write(3'd0, 8'h11); cfg_write(3'd1, 8'h22); cfg_write(3'd2, 8'h33);
      cfg_write(3'd3, 8'h44); cfg_write(3'd4, 8'h88); cfg_write(3'd5, 8'hE5);
      cfg_write(3'd6, 8'h80); cfg_write(3'd7, 8'hAF);
      cyc();
      check_regs("stage_idle");

      // Single note with start latency.
      push_note("rdy_single", mk(11'h1AB, 3'd3, 6'd40, 8'd2));
      start = 1'b1; cyc(); start = 1'b0;
      check("busy_fetch", 72'(busy), 72'(1));
      cyc();
      check_regs("latency_hold");
      cyc();
      check_load("single_load");
      run_note("single_ticks", 128);
      cyc();
      m_vol = '0;
      check_regs("starve_silence");
      check("busy_starve", 72'(busy), 72'(1));

      // Two identical notes then a rest, pushed while starving.
      a = mk(11'h2C5, 3'd1, 6'd17, 8'd2);
      r = mk(11'h3FF, 3'd2, 6'd0, 8'd1);
      push_note("rdy_b2b0", a); push_note("rdy_b2b1", a); push_note("rdy_rest", r);
      cyc();
      check_load("b2b_first");
      run_note("b2b_first_ticks", 128);
      cyc(); cyc();
      check_load("b2b_second");
      run_note("b2b_second_ticks", 128);
      cyc(); cyc();
      check_load("rest_load");
      run_note("rest_ticks", 64);
      cyc();
      m_vol = '0;
      check_regs("starve_after_rest");

      // Back to IDLE, fill the FIFO, overflow push is dropped.
      stop = 1'b1; cyc(); stop = 1'b0;
      check("stop_starve_busy", 72'(busy), 72'(0));
      check_regs("stop_starve_regs");
      for (int i = 0; i < 8; i++)
         push_note("rdy_fill", mk(11'(i * 150 + 9), 3'(i), 6'(i + 3), 8'd1));
      check("full_ready", 72'(note_ready), 72'(0));
      push_note("rdy_overflow", mk(11'h555, 3'd5, 6'd63, 8'd9));
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
      check("ready_after_pop", 72'(note_ready), 72'(1));
      cyc();
      check_load("fifo_first");

      // Partial play, then stop and start together.
      for (int i = 0; i < 10; i++) begin
         tick_8khz = 1'b1; #1;
         check("no_early_done", 72'(note_done), 72'(0));
         cyc(); tick_8khz = 1'b0; cyc();
      end
      stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
      m_vol = '0;
      check("stop_busy", 72'(busy), 72'(0));
      check_regs("stop_regs");
      check("stop_done", 72'(note_done), 72'(0));
      cyc(); cyc();
      check("stop_stays_idle", 72'(busy), 72'(0));
      push_note("rdy_retained", mk(11'h6A1, 3'd7, 6'd9, 8'd1));
      check("retained_full", 72'(note_ready), 72'(0));

      // Restart; staging written during PLAY waits for the next load.
      start = 1'b1; cyc(); start = 1'b0; cyc(); cyc();
      check_load("restart_load");
      cfg_write(3'd0, 8'h10);
      cyc();
      check("stg_hold", 72'(reg_1), 72'(8'h11));
      run_note("restart_ticks", 64);
      cyc(); cyc();
      check_load("stg_applied");

      // Flush (with a simultaneous push) then a duration-0 note.
      flush = 1'b1; note_valid = 1'b1; note_data = mk(11'h7AA, 3'd4, 6'd50, 8'd3);
      cyc();
      flush = 1'b0; note_valid = 1'b0;
      exp_q.delete(); mdl_cnt = 0;
      check("flush_ready", 72'(note_ready), 72'(1));
      push_note("rdy_dur0", mk(11'h0F0, 3'd6, 6'd20, 8'd0));
      run_note("pre_flush_note_ticks", 64);
      cyc(); cyc();
      check_load("dur0_load");
      run_note("dur0_ticks", 16384);
      cyc();
      m_vol = '0;
      check_regs("starve_after_dur0");

      // Asynchronous reset in the middle of a note.
      push_note("rdy_prereset", mk(11'h123, 3'd1, 6'd33, 8'd4));
      cyc(); cyc(); cyc();
      check_load("prereset_load");
      for (int i = 0; i < 5; i++) begin
         tick_8khz = 1'b1; cyc(); tick_8khz = 1'b0; cyc();
      end
      tick_8khz = 1'b1;
      reset_n = 1'b0;
      #2;
      model_reset();
      check_regs("async_rst_regs");
      check("async_rst_busy", 72'(busy), 72'(0));
      check("async_rst_ready", 72'(note_ready), 72'(1));
      check("async_rst_done", 72'(note_done), 72'(0));
      tick_8khz = 1'b0;
      cyc(); cyc();
      reset_n = 1'b1;
      cyc(); cyc(); cyc();
      check("post_rst_busy", 72'(busy), 72'(0));
      check_regs("post_rst_regs");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
